// File: rtl/uart_rx_ovs_pkg.sv
// Shared definitions for the oversampling UART receiver.
//   rx_state_e  : receiver FSM states
//   OVS_DEFAULT : default oversampling ratio
//   DBITS_W / DBITS_MIN / DATA_W_MAX : frame-format field widths and limits
//   rx_word_t   : one received word {pe, fe, data}
//   eff_dbits() : maps a programmed data-bit count onto the supported range
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } rx_state_e;

    localparam int unsigned OVS_DEFAULT = 16;
    localparam int unsigned DBITS_W     = 4;
    localparam int unsigned DBITS_MIN   = 5;
    localparam int unsigned DATA_W_MAX  = 9;

    // Data field is sized for the widest supported frame; narrower
    // builds zero-extend into it.
    typedef struct packed {
        logic                  pe;
        logic                  fe;
        logic [DATA_W_MAX-1:0] data;
    } rx_word_t;

    // Out-of-range data-bit counts fall back to the full word width.
    function automatic logic [DBITS_W-1:0] eff_dbits(input logic [DBITS_W-1:0] d,
                                                     input int unsigned max_w);
        int unsigned dv;
        dv = 32'(d);
        if (dv < DBITS_MIN || dv > max_w) begin
            return DBITS_W'(max_w);
        end
        return d;
    endfunction

endpackage

// File: rtl/uart_rx_ovs_if.sv
// Receive-word handshake between the UART receiver and its consumer.
//   data  : received word, LSB-first, unused MSBs zero
//   pe    : parity error for the word on data
//   fe    : framing error for the word on data
//   valid : word available
//   ready : consumer accepts the word (transfer on valid & ready)
// Modports: master = receiver side, slave = consumer side.
interface uart_rx_ovs_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] data;
    logic              pe;
    logic              fe;
    logic              valid;
    logic              ready;

    modport master (output data, output pe, output fe, output valid, input ready);
    modport slave  (input data, input pe, input fe, input valid, output ready);
endinterface

// File: rtl/uart_rx_ovs_fifo.sv
// Synchronous first-word-fall-through FIFO for received UART words.
// Only built when UART_RX_FIFO_EN is defined.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push, wdata   : write request and word
//   pop           : read request (head advances)
//   rdata         : head entry, zero while empty
//   empty, full   : occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A push while full is accepted only together with a pop.
`ifdef UART_RX_FIFO_EN
module uart_rx_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_en;
    logic             pop_en;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_en  = pop & ~empty;
    assign push_en = push & (~full | pop_en);
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_en) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule
`endif

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: serial rx_i -> parallel words on a valid/ready port.
// Own baud tick generator, 3-sample majority vote per bit, runtime frame format
// (5..DATA_W data bits, optional parity, 1 or 2 stop bits), parity/framing/overrun flags.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   rx_i            : asynchronous serial input, idles high
//   cfg_en_i        : receiver enable; low aborts any frame in progress
//   cfg_div_i       : clk_i cycles per oversample tick, minus 1
//   cfg_dbits_i     : data bits per frame (out-of-range -> DATA_W)
//   cfg_pce_i       : parity enable; cfg_ps_i: 0 even, 1 odd
//   cfg_stop2_i     : two stop bits
//   bus (master)    : data/pe/fe/valid out, ready in
//   ore_o           : sticky overrun; err_clr_i clears it
//   busy_o          : frame in progress
// Build option: UART_RX_FIFO_EN selects a FIFO_DEPTH-entry FIFO instead of a
// single holding register.
module uart_rx_ovs
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned OVS        = OVS_DEFAULT,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               rx_i,
    input  logic               cfg_en_i,
    input  logic [DIV_W-1:0]   cfg_div_i,
    input  logic [DBITS_W-1:0] cfg_dbits_i,
    input  logic               cfg_pce_i,
    input  logic               cfg_ps_i,
    input  logic               cfg_stop2_i,
    uart_rx_ovs_if.master      bus,
    output logic               ore_o,
    input  logic               err_clr_i,
    output logic               busy_o
);
    localparam int unsigned SCNT_W = $clog2(OVS);
    localparam logic [SCNT_W-1:0] VOTE0 = SCNT_W'(OVS/2 - 1);
    localparam logic [SCNT_W-1:0] VOTE1 = SCNT_W'(OVS/2);
    localparam logic [SCNT_W-1:0] VOTE2 = SCNT_W'(OVS/2 + 1);
    localparam logic [SCNT_W-1:0] LAST  = SCNT_W'(OVS - 1);

    if (OVS < 8 || (OVS % 2) != 0 || DATA_W < DBITS_MIN || DATA_W > DATA_W_MAX ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $error("uart_rx_ovs: unsupported parameter set");
    end

    // ---------------------------------------------------------------
    // Input synchroniser and falling-edge detect
    // ---------------------------------------------------------------
    logic rx_s1, rx_s2, rx_d;
    logic fall;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx_i;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    assign fall = rx_d & ~rx_s2;

    // ---------------------------------------------------------------
    // State and timing
    // ---------------------------------------------------------------
    rx_state_e state_q, state_d;

    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_q;
    logic [SCNT_W-1:0] s_cnt;
    logic              tick;
    logic              decide;
    logic              bit_end;
    logic              v0_q, v1_q;
    logic              vote;

    // Divider is held at zero while idle, so the first tick of a frame is
    // measured from the cycle the start edge was seen. The divisor is only
    // reloaded at wrap (or while idle) so a change never truncates a tick.
    assign tick = (state_q != IDLE) && (div_cnt == div_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt <= '0;
            div_q   <= '0;
            s_cnt   <= '0;
        end else if (state_q == IDLE) begin
            div_cnt <= '0;
            div_q   <= cfg_div_i;
            s_cnt   <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            div_q   <= cfg_div_i;
            s_cnt   <= (s_cnt == LAST) ? '0 : s_cnt + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v0_q <= 1'b1;
            v1_q <= 1'b1;
        end else if (tick) begin
            if (s_cnt == VOTE0) v0_q <= rx_s2;
            if (s_cnt == VOTE1) v1_q <= rx_s2;
        end
    end

    // Third sample is taken live on the deciding tick.
    assign vote    = (v0_q & v1_q) | (v0_q & rx_s2) | (v1_q & rx_s2);
    assign decide  = tick && (s_cnt == VOTE2);
    assign bit_end = tick && (s_cnt == LAST);

    // ---------------------------------------------------------------
    // Per-frame registers
    // ---------------------------------------------------------------
    logic [DBITS_W-1:0] dbits_q;
    logic               pce_q, ps_q, stop2_q;
    logic [DBITS_W-1:0] bit_idx_q;
    logic [DATA_W-1:0]  data_q;
    logic               pe_q, fe_q;
    logic               start_go;

    assign start_go = (state_q == IDLE) && cfg_en_i && fall;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dbits_q   <= '0;
            pce_q     <= 1'b0;
            ps_q      <= 1'b0;
            stop2_q   <= 1'b0;
            bit_idx_q <= '0;
            data_q    <= '0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
        end else if (start_go) begin
            dbits_q   <= eff_dbits(cfg_dbits_i, DATA_W);
            pce_q     <= cfg_pce_i;
            ps_q      <= cfg_ps_i;
            stop2_q   <= cfg_stop2_i;
            bit_idx_q <= '0;
            data_q    <= '0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
        end else if (decide) begin
            case (state_q)
                DATA: begin
                    data_q    <= data_q | (DATA_W'(vote) << bit_idx_q);
                    bit_idx_q <= bit_idx_q + 1'b1;
                end
                PARITY: pe_q <= (vote != (ps_q ^ (^data_q)));
                STOP1:  fe_q <= ~vote;
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // FSM next state; final stop bit pushes on its decision tick
    // ---------------------------------------------------------------
    logic push;

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_go) state_d = START;
            end
            START: begin
                if (decide && vote) state_d = IDLE;
                else if (bit_end)   state_d = DATA;
            end
            DATA: begin
                // bit_idx_q was advanced on this bit's decision tick
                if (bit_end && bit_idx_q == dbits_q) state_d = pce_q ? PARITY : STOP1;
            end
            PARITY: begin
                if (bit_end) state_d = STOP1;
            end
            STOP1: begin
                if (decide && !stop2_q) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d = STOP2;
                end
            end
            STOP2: begin
                if (decide) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!cfg_en_i) begin
            push    = 1'b0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    assign busy_o = (state_q != IDLE);

    // fe_q is already 0 on a single-stop frame, so ORing is safe for both.
    rx_word_t push_word;
    always_comb begin
        push_word      = '0;
        push_word.pe   = pe_q;
        push_word.fe   = fe_q | ~vote;
        push_word.data = DATA_W_MAX'(data_q);
    end

    // ---------------------------------------------------------------
    // Word storage and overrun
    // ---------------------------------------------------------------
    logic full;
    logic pop;
    logic overrun;

`ifdef UART_RX_FIFO_EN
    logic [DATA_W+1:0] fifo_rdata;
    logic              fifo_empty;

    uart_rx_fifo #(
        .WIDTH (DATA_W + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push),
        .wdata  ({push_word.pe, push_word.fe, DATA_W'(push_word.data)}),
        .pop    (pop),
        .rdata  (fifo_rdata),
        .empty  (fifo_empty),
        .full   (full)
    );

    assign pop       = ~fifo_empty & bus.ready;
    assign bus.valid = ~fifo_empty;
    assign bus.pe    = fifo_rdata[DATA_W+1];
    assign bus.fe    = fifo_rdata[DATA_W];
    assign bus.data  = fifo_rdata[DATA_W-1:0];
`else
    rx_word_t word_q;
    logic     valid_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q  <= '0;
            valid_q <= 1'b0;
        end else if (push && (!valid_q || pop)) begin
            word_q  <= push_word;
            valid_q <= 1'b1;
        end else if (pop) begin
            valid_q <= 1'b0;
        end
    end

    assign full      = valid_q;
    assign pop       = valid_q & bus.ready;
    assign bus.valid = valid_q;
    assign bus.pe    = word_q.pe;
    assign bus.fe    = word_q.fe;
    assign bus.data  = DATA_W'(word_q.data);
`endif

    // A pop in the same cycle frees the slot, so that push is not an overrun.
    assign overrun = push & full & ~pop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)        ore_o <= 1'b0;
        else if (overrun)   ore_o <= 1'b1;
        else if (err_clr_i) ore_o <= 1'b0;
    end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed self-checking bench for uart_rx_ovs (div=3, OVS=16 -> 64 clocks per bit).
module tb_uart_rx_ovs;
    localparam int unsigned DIV = 3;
    localparam int unsigned BIT = 16 * (DIV + 1);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx;
    logic        cfg_en;
    logic [15:0] cfg_div;
    logic [3:0]  cfg_dbits;
    logic        cfg_pce, cfg_ps, cfg_stop2;
    logic        ore, err_clr, busy;

    int checks   = 0;
    int failures = 0;
    int xfer_cnt = 0;
    int exp_x    = 0;
    logic [7:0] x_data = '0;
    logic       x_pe = 1'b0;
    logic       x_fe = 1'b0;

    uart_rx_ovs_if #(.DATA_W(8)) bus ();

    uart_rx_ovs #(
        .DATA_W     (8),
        .OVS        (16),
        .DIV_W      (16),
        .FIFO_DEPTH (8)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .rx_i        (rx),
        .cfg_en_i    (cfg_en),
        .cfg_div_i   (cfg_div),
        .cfg_dbits_i (cfg_dbits),
        .cfg_pce_i   (cfg_pce),
        .cfg_ps_i    (cfg_ps),
        .cfg_stop2_i (cfg_stop2),
        .bus         (bus),
        .ore_o       (ore),
        .err_clr_i   (err_clr),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.valid && bus.ready) begin
            xfer_cnt <= xfer_cnt + 1;
            x_data   <= bus.data;
            x_pe     <= bus.pe;
            x_fe     <= bus.fe;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        cyc(BIT);
    endtask

    task automatic send_frame(input logic [8:0] d, input int nd, input bit has_par,
                              input logic par, input logic s1, input bit has_s2,
                              input logic s2);
        send_bit(1'b0);
        for (int i = 0; i < nd; i++) send_bit(d[i]);
        if (has_par) send_bit(par);
        send_bit(s1);
        if (has_s2) send_bit(s2);
        rx = 1'b1;
        cyc(BIT);
    endtask

    task automatic wait_xfer(input string tag);
        for (int i = 0; i < 4 * BIT && xfer_cnt < exp_x; i++) @(negedge clk);
        check(tag, 32'(xfer_cnt), 32'(exp_x));
    endtask

    task automatic check_word(input string tag, input logic [7:0] d, input logic pe,
                              input logic fe);
        check({tag, "_data"}, 32'(x_data), 32'(d));
        check({tag, "_pe"}, 32'(x_pe), 32'(pe));
        check({tag, "_fe"}, 32'(x_fe), 32'(fe));
    endtask

    initial begin
        rx        = 1'b1;
        rst_n     = 1'b0;
        cfg_en    = 1'b0;
        cfg_div   = 16'(DIV);
        cfg_dbits = 4'd8;
        cfg_pce   = 1'b0;
        cfg_ps    = 1'b0;
        cfg_stop2 = 1'b0;
        err_clr   = 1'b0;
        bus.ready = 1'b0;
        cyc(3);

        // Reset state
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_data", 32'(bus.data), 32'd0);
        check("rst_pe_fe", 32'({bus.pe, bus.fe}), 32'd0);
        check("rst_ore", 32'(ore), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n     = 1'b1;
        cfg_en    = 1'b1;
        bus.ready = 1'b1;
        cyc(20);

        // 8N1 0xA5
        send_frame(9'h0A5, 8, 0, 1'b0, 1'b1, 0, 1'b1);
        exp_x = 1;
        wait_xfer("t1_count");
        check_word("t1", 8'hA5, 1'b0, 1'b0);

        // 7E1 0x35 (four ones -> even parity bit 0)
        cfg_dbits = 4'd7;
        cfg_pce   = 1'b1;
        send_frame(9'h035, 7, 1, 1'b0, 1'b1, 0, 1'b1);
        exp_x = 2;
        wait_xfer("t2a_count");
        check_word("t2a", 8'h35, 1'b0, 1'b0);
        send_frame(9'h035, 7, 1, 1'b1, 1'b1, 0, 1'b1);
        exp_x = 3;
        wait_xfer("t2b_count");
        check_word("t2b", 8'h35, 1'b1, 1'b0);
        // 7O1: odd parity bit for 0x35 is 1
        cfg_ps = 1'b1;
        send_frame(9'h035, 7, 1, 1'b1, 1'b1, 0, 1'b1);
        exp_x = 4;
        wait_xfer("t2c_count");
        check_word("t2c", 8'h35, 1'b0, 1'b0);

        // 8N2 with second stop bit low
        cfg_dbits = 4'd8;
        cfg_pce   = 1'b0;
        cfg_ps    = 1'b0;
        cfg_stop2 = 1'b1;
        send_frame(9'h03C, 8, 0, 1'b0, 1'b1, 1, 1'b0);
        exp_x = 5;
        wait_xfer("t3_count");
        check_word("t3", 8'h3C, 1'b0, 1'b1);

        // 3-cycle glitch on idle line: false start
        cfg_stop2 = 1'b0;
        rx = 1'b0;
        cyc(3);
        rx = 1'b1;
        cyc(10);
        check("glitch_busy_on", 32'(busy), 32'd1);
        cyc(2 * BIT);
        check("glitch_busy_off", 32'(busy), 32'd0);
        check("glitch_no_word", 32'(xfer_cnt), 32'd5);

        // Out-of-range dbits falls back to 8; then 5-bit frame
        cfg_dbits = 4'd0;
        send_frame(9'h0C3, 8, 0, 1'b0, 1'b1, 0, 1'b1);
        exp_x = 6;
        wait_xfer("dbits0_count");
        check("dbits0_data", 32'(x_data), 32'hC3);
        cfg_dbits = 4'd5;
        send_frame(9'h01B, 5, 0, 1'b0, 1'b1, 0, 1'b1);
        exp_x = 7;
        wait_xfer("dbits5_count");
        check("dbits5_data", 32'(x_data), 32'h1B);
        cfg_dbits = 4'd8;

`ifdef UART_RX_FIFO_EN
        // Fill 8-deep FIFO plus one
        bus.ready = 1'b0;
        for (int k = 0; k < 9; k++) send_frame(9'(k), 8, 0, 1'b0, 1'b1, 0, 1'b1);
        check("fifo_ore", 32'(ore), 32'd1);
        check("fifo_valid", 32'(bus.valid), 32'd1);
        bus.ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("fifo_pop_data", 32'(bus.data), 32'(k));
            @(negedge clk);
        end
        check("fifo_drained", 32'(bus.valid), 32'd0);
        exp_x = 15;
        check("fifo_pop_count", 32'(xfer_cnt), 32'(exp_x));
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        check("fifo_ore_clr", 32'(ore), 32'd0);
`else
        // Overrun with the holding register
        bus.ready = 1'b0;
        send_frame(9'h011, 8, 0, 1'b0, 1'b1, 0, 1'b1);
        check("ovr_valid1", 32'(bus.valid), 32'd1);
        check("ovr_data1", 32'(bus.data), 32'h11);
        check("ovr_ore0", 32'(ore), 32'd0);
        send_frame(9'h022, 8, 0, 1'b0, 1'b1, 0, 1'b1);
        check("ovr_ore1", 32'(ore), 32'd1);
        check("ovr_data_kept", 32'(bus.data), 32'h11);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        check("ovr_clr", 32'(ore), 32'd0);
        bus.ready = 1'b1;
        cyc(2);
        exp_x = 8;
        check("ovr_pop_count", 32'(xfer_cnt), 32'(exp_x));
        check("ovr_pop_data", 32'(x_data), 32'h11);
        check("ovr_pop_valid", 32'(bus.valid), 32'd0);
`endif

        // Enable dropped mid-DATA: frame discarded
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        cfg_en = 1'b0;
        cyc(2);
        check("en_drop_busy", 32'(busy), 32'd0);
        rx = 1'b1;
        cyc(2 * BIT);
        cfg_en = 1'b1;
        cyc(2);
        check("en_drop_no_word", 32'(xfer_cnt), 32'(exp_x));
        check("en_drop_valid", 32'(bus.valid), 32'd0);

        // Pending word plus overrun, then reset mid-frame
        bus.ready = 1'b0;
        send_frame(9'h077, 8, 0, 1'b0, 1'b1, 0, 1'b1);
        send_frame(9'h066, 8, 0, 1'b0, 1'b1, 0, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rst_n = 1'b0;
        #1;
        check("mrst_valid", 32'(bus.valid), 32'd0);
        check("mrst_data", 32'(bus.data), 32'd0);
        check("mrst_pe_fe", 32'({bus.pe, bus.fe}), 32'd0);
        check("mrst_ore", 32'(ore), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        cyc(2);
        rst_n = 1'b1;
        rx    = 1'b1;
        cyc(2 * BIT);
        check("mrst_no_word", 32'(bus.valid), 32'd0);

        // Next frame after reset
        bus.ready = 1'b1;
        send_frame(9'h05A, 8, 0, 1'b0, 1'b1, 0, 1'b1);
        exp_x = exp_x + 1;
        wait_xfer("post_rst_count");
        check_word("post_rst", 8'h5A, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
